mul_hilo_sequencer: RTL and testbench

- Multi-cycle control and writeback stage for the datapath's 32x32 signed multiply.
- Registers the operands that drive the combinational Booth multiplier, waits a fixed settle interval (multicycle path), then captures the 64-bit product into the HI/LO registers.
- Also services direct HI/LO writes (mthi/mtlo).
- HI/LO outputs feed the bus mux for mfhi/mflo.

---
 rtl/mul_hilo_sequencer_pkg.sv | 7 +
 rtl/mul_hilo_sequencer_hilo_regs.sv | 26 ++
 rtl/mul_hilo_sequencer.sv | 66 ++++++
 tb/tb_mul_hilo_sequencer.sv | 136 +++++++++++++
 4 files changed

// File: rtl/mul_hilo_sequencer_pkg.sv
// mul_hilo_sequencer_pkg: shared state encoding and default sizes for the multiply sequencer
package mul_hilo_sequencer_pkg;
  typedef enum logic {IDLE = 1'b0, SETTLE = 1'b1} state_e;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_PWIDTH = 2 * DEF_WIDTH;
  localparam int DEF_SETTLE = 4;
endpackage

// File: rtl/mul_hilo_sequencer_hilo_regs.sv
// hilo_regs: HI/LO register pair; a product capture outranks direct mthi/mtlo writes
module hilo_regs
  import mul_hilo_sequencer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cap_i,
  input  logic [2*WIDTH-1:0] prod_i,
  input  logic               wr_hi_i,
  input  logic               wr_lo_i,
  input  logic [WIDTH-1:0]   wr_data_i,
  output logic [WIDTH-1:0]   hi_o,
  output logic [WIDTH-1:0]   lo_o
);
  always_ff @(posedge clock) begin
    if (reset) begin
      hi_o <= '0;
      lo_o <= '0;
    end else begin
      hi_o <= cap_i ? prod_i[2*WIDTH-1:WIDTH] : wr_hi_i ? wr_data_i : hi_o;
      lo_o <= cap_i ? prod_i[WIDTH-1:0] : wr_lo_i ? wr_data_i : lo_o;
    end
  end
endmodule

// File: rtl/mul_hilo_sequencer.sv
// mul_hilo_sequencer: registers multiply operands, waits out the multicycle settle, captures HI/LO
module mul_hilo_sequencer
  import mul_hilo_sequencer_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int SETTLE_CYCLES = DEF_SETTLE
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   op_q,
  input  logic [WIDTH-1:0]   op_m,
  output logic [WIDTH-1:0]   mul_q,
  output logic [WIDTH-1:0]   mul_m,
  input  logic [2*WIDTH-1:0] mul_p,
  input  logic               wr_hi,
  input  logic               wr_lo,
  input  logic [WIDTH-1:0]   wr_data,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   hi_out,
  output logic [WIDTH-1:0]   lo_out
);
  localparam int CW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          cap;
  assign cap = (state_q == SETTLE) && (cnt_q == '0);
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mul_q   <= '0;
      mul_m   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= cap;
      if (state_q == IDLE) begin
        if (start) begin
          mul_q   <= op_q;
          mul_m   <= op_m;
          cnt_q   <= CW'(SETTLE_CYCLES - 1);
          state_q <= SETTLE;
          busy    <= 1'b1;
        end
      end else if (cap) begin
        state_q <= IDLE;
        busy    <= 1'b0;
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end
  hilo_regs #(.WIDTH(WIDTH)) u_hilo (
    .clock    (clock),
    .reset    (reset),
    .cap_i    (cap),
    .prod_i   (mul_p),
    .wr_hi_i  (wr_hi),
    .wr_lo_i  (wr_lo),
    .wr_data_i(wr_data),
    .hi_o     (hi_out),
    .lo_o     (lo_out)
  );
endmodule

// File: tb/tb_mul_hilo_sequencer.sv
// tb_mul_hilo_sequencer: checks SETTLE_CYCLES=4 and =1 instances against a cycle-level reference model
module tb_mul_hilo_sequencer;
  logic        clock = 1'b0;
  logic        reset, start, wr_hi, wr_lo;
  logic [31:0] op_q, op_m, wr_data;
  logic [31:0] mq [2], mm [2], hi [2], lo [2];
  logic [63:0] mp [2];
  logic        busy [2], done [2];
  int          errors = 0, checks = 0;
  logic [31:0] e_hi [2], e_lo [2], e_q [2], e_m [2];
  bit          e_busy [2], e_done [2];
  int          rem [2];
  int          sc [2] = '{4, 1};
  always #5 clock = ~clock;
  function automatic logic [63:0] prod(input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'(signed'(a));
    longint sb = longint'(signed'(b));
    return 64'(sa * sb);
  endfunction
  assign mp[0] = prod(mq[0], mm[0]);
  assign mp[1] = prod(mq[1], mm[1]);
  mul_hilo_sequencer #(.WIDTH(32), .SETTLE_CYCLES(4)) dut4 (
    .clock(clock), .reset(reset), .start(start), .op_q(op_q), .op_m(op_m),
    .mul_q(mq[0]), .mul_m(mm[0]), .mul_p(mp[0]), .wr_hi(wr_hi), .wr_lo(wr_lo),
    .wr_data(wr_data), .busy(busy[0]), .done(done[0]), .hi_out(hi[0]), .lo_out(lo[0])
  );
  mul_hilo_sequencer #(.WIDTH(32), .SETTLE_CYCLES(1)) dut1 (
    .clock(clock), .reset(reset), .start(start), .op_q(op_q), .op_m(op_m),
    .mul_q(mq[1]), .mul_m(mm[1]), .mul_p(mp[1]), .wr_hi(wr_hi), .wr_lo(wr_lo),
    .wr_data(wr_data), .busy(busy[1]), .done(done[1]), .hi_out(hi[1]), .lo_out(lo[1])
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic model(input int k);
    logic [63:0] p;
    if (reset) begin
      e_hi[k] = '0; e_lo[k] = '0; e_q[k] = '0; e_m[k] = '0;
      e_busy[k] = 0; e_done[k] = 0; rem[k] = 0;
    end else begin
      e_done[k] = 0;
      if (wr_hi) e_hi[k] = wr_data;
      if (wr_lo) e_lo[k] = wr_data;
      if (rem[k] > 0) begin
        rem[k]--;
        if (rem[k] == 0) begin
          p = prod(e_q[k], e_m[k]);
          e_hi[k] = p[63:32];
          e_lo[k] = p[31:0];
          e_done[k] = 1;
          e_busy[k] = 0;
        end
      end else if (start) begin
        e_q[k] = op_q; e_m[k] = op_m; rem[k] = sc[k]; e_busy[k] = 1;
      end
    end
  endtask
  task automatic step(input bit st, input logic [31:0] q, input logic [31:0] m,
                      input bit wh, input bit wl, input logic [31:0] wd, input bit rs);
    @(negedge clock);
    start = st; op_q = q; op_m = m; wr_hi = wh; wr_lo = wl; wr_data = wd; reset = rs;
    @(posedge clock);
    for (int k = 0; k < 2; k++) model(k);
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("busy%0d", k), 64'(busy[k]), 64'(e_busy[k]));
      check($sformatf("done%0d", k), 64'(done[k]), 64'(e_done[k]));
      check($sformatf("hi%0d", k), 64'(hi[k]), 64'(e_hi[k]));
      check($sformatf("lo%0d", k), 64'(lo[k]), 64'(e_lo[k]));
      check($sformatf("mul_q%0d", k), 64'(mq[k]), 64'(e_q[k]));
      check($sformatf("mul_m%0d", k), 64'(mm[k]), 64'(e_m[k]));
    end
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, $urandom, $urandom, 0, 0, $urandom, 0);
  endtask
  initial begin
    step(0, 0, 0, 0, 0, 0, 1);
    check("reset_hi", 64'(hi[0]), 64'h0);
    step(1, 7, 3, 0, 0, 0, 0);
    check("busy_7x3", 64'(busy[0]), 64'h1);
    idle(3);
    check("busy_last", 64'(busy[0]), 64'h1);
    idle(1);
    check("lo_7x3", 64'(lo[0]), 64'h15);
    check("hi_7x3", 64'(hi[0]), 64'h0);
    check("done_7x3", 64'(done[0]), 64'h1);
    idle(1);
    check("done_drop", 64'(done[0]), 64'h0);
    step(1, 32'hFFFFFFFE, 3, 0, 0, 0, 0);
    idle(4);
    check("hi_neg", 64'(hi[0]), 64'hFFFFFFFF);
    check("lo_neg", 64'(lo[0]), 64'hFFFFFFFA);
    step(1, 5, 5, 0, 0, 0, 0);
    idle(1);
    step(1, 9, 9, 0, 0, 0, 0);
    check("ignored_q", 64'(mq[0]), 64'h5);
    idle(2);
    check("lo_5x5", 64'(lo[0]), 64'h19);
    step(1, 9, 9, 0, 0, 0, 0);
    idle(4);
    check("lo_9x9", 64'(lo[0]), 64'h51);
    step(1, 32'h10000, 32'h10000, 0, 0, 0, 0);
    idle(1);
    step(0, 0, 0, 0, 0, 0, 1);
    check("abort_busy", 64'(busy[0]), 64'h0);
    check("abort_hi", 64'(hi[0]), 64'h0);
    idle(4);
    check("abort_nodone", 64'(done[0]), 64'h0);
    step(1, 7, 3, 0, 0, 0, 0);
    idle(4);
    check("lo_after_abort", 64'(lo[0]), 64'h15);
    step(0, 0, 0, 1, 0, 32'hDEADBEEF, 0);
    check("mthi", 64'(hi[0]), 64'hDEADBEEF);
    step(1, 2, 2, 0, 0, 0, 0);
    idle(3);
    step(0, 0, 0, 0, 1, 32'h12345678, 0);
    check("collide_lo", 64'(lo[0]), 64'h4);
    idle(1);
    step(1, 6, 7, 0, 0, 0, 0);
    check("s1_busy", 64'(busy[1]), 64'h1);
    idle(1);
    check("s1_lo", 64'(lo[1]), 64'h2A);
    check("s1_done", 64'(done[1]), 64'h1);
    check("s1_busy_off", 64'(busy[1]), 64'h0);
    for (int i = 0; i < 400; i++)
      step($urandom_range(2) == 0, $urandom, $urandom, $urandom_range(5) == 0,
           $urandom_range(5) == 0, $urandom, $urandom_range(39) == 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
